// File: rtl/udp_reg_ring_master_pkg.sv
// rtl/udp_reg_ring_master_pkg.sv - shared UDP register ring widths, constants, error codes and states
// Contents: ring address/data widths, the filler word returned on failed accesses,
//           host error codes and the master FSM state encoding.
package udp_reg_ring_master_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] DEAD_BEEF = 32'hDEAD_BEEF;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/udp_reg_ring_master_if.sv
// rtl/udp_reg_ring_master_if.sv - host access port plus ring head/tail bundle for the ring master
// Signals: host_req_valid/ready, host_rd_wr_L, host_addr, host_wr_data (host request);
//          host_resp_valid, host_rd_data, host_err (host response);
//          reg_*_out (ring head, driven by master), reg_*_in (ring tail, seen by master).
// Modports: master = ring master view, slave = host + ring environment view.
interface udp_reg_ring_master_if
    import udp_reg_ring_master_pkg::*;
#(
    parameter int SRC_WIDTH = 2
) ();

    logic                           host_req_valid;
    logic                           host_req_ready;
    logic                           host_rd_wr_L;
    logic [UDP_REG_ADDR_WIDTH-1:0]  host_addr;
    logic [CPCI_NF2_DATA_WIDTH-1:0] host_wr_data;
    logic                           host_resp_valid;
    logic [CPCI_NF2_DATA_WIDTH-1:0] host_rd_data;
    logic [1:0]                     host_err;

    logic                           reg_req_out;
    logic                           reg_ack_out;
    logic                           reg_rd_wr_L_out;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
    logic [SRC_WIDTH-1:0]           reg_src_out;

    logic                           reg_req_in;
    logic                           reg_ack_in;
    logic                           reg_rd_wr_L_in;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
    logic [SRC_WIDTH-1:0]           reg_src_in;

    modport master (
        input  host_req_valid, host_rd_wr_L, host_addr, host_wr_data,
        output host_req_ready, host_resp_valid, host_rd_data, host_err,
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
    );

    modport slave (
        output host_req_valid, host_rd_wr_L, host_addr, host_wr_data,
        input  host_req_ready, host_resp_valid, host_rd_data, host_err,
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
    );

endinterface

// File: rtl/udp_reg_ring_master_timeout_ctr.sv
// rtl/udp_reg_ring_master_timeout_ctr.sv - clear/enable counter that flags a ring return timeout
// Ports: clk, reset_n (async active-low), clear (zero the count), enable (count this cycle),
//        expire (enabled cycle whose increment reaches TIMEOUT_CYCLES-1).
module udp_reg_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TIMEOUT_WIDTH  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // Expire is raised on the cycle that would bump the count to TIMEOUT_CYCLES-1, so the
    // owner sees the timeout TIMEOUT_CYCLES cycles after the cycle in which it cleared us.
    localparam logic [TIMEOUT_WIDTH-1:0] EXPIRE_AT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 2);

    logic [TIMEOUT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == EXPIRE_AT);

endmodule

// File: rtl/udp_reg_ring_master.sv
// rtl/udp_reg_ring_master.sv - UDP register ring head: issues one host access, waits for its return
// Ports: clk, reset_n (async active-low), bus (udp_reg_ring_master_if.master: host request/response
//        and ring head/tail), stray_count (saturating count of discarded ring returns).
module udp_reg_ring_master
    import udp_reg_ring_master_pkg::*;
#(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int SRC_ID            = 0,
    parameter int TIMEOUT_CYCLES    = 1023,
    parameter int TIMEOUT_WIDTH     = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    udp_reg_ring_master_if.master  bus,
    output logic [15:0]            stray_count
);

    localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ID);

    state_e                        state, next_state;
    logic [UDP_REG_ADDR_WIDTH-1:0] cap_addr;
    logic                          ready_q;
    logic                          match;
    logic                          expire;
    logic                          stray;

    // A return is ours only if it carries our tag and the address we sent out.
    assign match = bus.reg_req_in && (bus.reg_src_in == SRC_TAG) && (bus.reg_addr_in == cap_addr);
    assign stray = bus.reg_req_in && !((state == ST_WAIT) && match);

    // Ready is registered so it reads 0 while reset is held and rises one cycle after release.
    assign bus.host_req_ready = ready_q;

    udp_reg_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (ready_q && bus.host_req_valid) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (match || expire) next_state = ST_RESP;
            ST_RESP:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q             <= 1'b0;
            cap_addr            <= '0;
            bus.reg_req_out     <= 1'b0;
            bus.reg_ack_out     <= 1'b0;
            bus.reg_rd_wr_L_out <= 1'b0;
            bus.reg_addr_out    <= '0;
            bus.reg_data_out    <= '0;
            bus.reg_src_out     <= '0;
            bus.host_resp_valid <= 1'b0;
            bus.host_rd_data    <= '0;
            bus.host_err        <= ERR_OK;
            stray_count         <= '0;
        end else begin
            ready_q             <= (next_state == ST_IDLE);
            bus.host_resp_valid <= (state == ST_WAIT) && (next_state == ST_RESP);

            // Ring head is registered and idles at zero; loading it on acceptance puts the
            // request on the ring for exactly the ISSUE cycle.
            bus.reg_req_out     <= 1'b0;
            bus.reg_ack_out     <= 1'b0;
            bus.reg_rd_wr_L_out <= 1'b0;
            bus.reg_addr_out    <= '0;
            bus.reg_data_out    <= '0;
            bus.reg_src_out     <= '0;
            if ((state == ST_IDLE) && (next_state == ST_ISSUE)) begin
                cap_addr            <= bus.host_addr;
                bus.reg_req_out     <= 1'b1;
                bus.reg_rd_wr_L_out <= bus.host_rd_wr_L;
                bus.reg_addr_out    <= bus.host_addr;
                bus.reg_data_out    <= bus.host_rd_wr_L ? '0 : bus.host_wr_data;
                bus.reg_src_out     <= SRC_TAG;
            end

            // A match on the same cycle as expiry completes normally.
            if ((state == ST_WAIT) && match) begin
                bus.host_rd_data <= bus.reg_ack_in ? bus.reg_data_in : DEAD_BEEF;
                bus.host_err     <= bus.reg_ack_in ? ERR_OK : ERR_NOACK;
            end else if ((state == ST_WAIT) && expire) begin
                bus.host_rd_data <= DEAD_BEEF;
                bus.host_err     <= ERR_TIMEOUT;
            end

            if (stray && (stray_count != 16'hFFFF)) begin
                stray_count <= stray_count + 16'd1;
            end
        end
    end

endmodule
